// File: rtl/ysyx_24080014_pkg.sv
// Shared writeback types: trap control codes, CSR addresses,
// the writeback request bundle and a write-effect helper.
package ysyx_24080014_pkg;

  typedef enum logic [1:0] {
    CSRS_NONE  = 2'd0,
    CSRS_ECALL = 2'd1,
    CSRS_MRET  = 2'd2
  } csrs_ctl_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int WB_XLEN = 32;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
    logic [1:0]         csrs_ctl;
    logic [11:0]        csr_waddr;
    logic [WB_XLEN-1:0] pc;
  } wb_req_t;

  // A staged write touches the register file only if it
  // names a GPR other than x0 or carries a CSR effect.
  function automatic logic wb_has_effect(
    input logic [4:0]  rd,
    input logic [1:0]  ctl,
    input logic [11:0] waddr
  );
    return (rd != 5'd0) || (ctl != 2'd0) ||
           (waddr != 12'd0);
  endfunction

endpackage

// File: rtl/ysyx_24080014_wb_arb_if.sv
// Writeback bus: EXU and LSU request channels plus the
// register-file write port and retire outputs.
interface ysyx_24080014_wb_arb_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic            exu_valid;
  logic            exu_ready;
  logic [4:0]      exu_rd;
  logic [XLEN-1:0] exu_data;
  logic [1:0]      exu_csrs_ctl;
  logic [11:0]     exu_csr_waddr;
  logic [XLEN-1:0] exu_pc;

  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic [XLEN-1:0] lsu_pc;

  logic             RegWr;
  logic [4:0]       rd;
  logic [XLEN-1:0]  rd_data;
  logic [1:0]       csrs_ctl;
  logic [11:0]      csrs_rs1_write_add;
  logic [XLEN-1:0]  pc;
  logic             retire;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output exu_valid, exu_rd, exu_data,
    output exu_csrs_ctl, exu_csr_waddr, exu_pc,
    output lsu_valid, lsu_rd, lsu_data, lsu_pc,
    input  exu_ready, lsu_ready,
    input  RegWr, rd, rd_data, csrs_ctl,
    input  csrs_rs1_write_add, pc,
    input  retire, retire_cnt
  );

  modport slave (
    input  exu_valid, exu_rd, exu_data,
    input  exu_csrs_ctl, exu_csr_waddr, exu_pc,
    input  lsu_valid, lsu_rd, lsu_data, lsu_pc,
    output exu_ready, lsu_ready,
    output RegWr, rd, rd_data, csrs_ctl,
    output csrs_rs1_write_add, pc,
    output retire, retire_cnt
  );

endinterface

// File: rtl/ysyx_24080014_rr_arb2.sv
// Two-way EXU/LSU grant with last-winner tracking.
// YSYX_24080014_WB_RR_EN selects round-robin tie-break.
module ysyx_24080014_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic req_exu,
  input  logic req_lsu,
  output logic gnt_exu,
  output logic gnt_lsu
);

  // 0 = EXU won last, 1 = LSU won last
  logic last_q, last_d;
  logic tie_lsu;

  always_comb begin
`ifdef YSYX_24080014_WB_RR_EN
    tie_lsu = ~last_q;
`else
    tie_lsu = 1'b1;
`endif
    gnt_lsu = !hold && req_lsu &&
              (!req_exu || tie_lsu);
    gnt_exu = !hold && req_exu &&
              (!req_lsu || !tie_lsu);
    last_d = last_q;
    unique case (1'b1)
      gnt_lsu: last_d = 1'b1;
      gnt_exu: last_d = 1'b0;
      default: last_d = last_q;
    endcase
  end

  // Reset to LSU so EXU takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/ysyx_24080014_wb_arb.sv
// Writeback arbiter: one registered write stage shared by
// EXU and LSU; retire pulse/counter. Macro: YSYX_24080014_WB_RR_EN.
module ysyx_24080014_wb_arb
  import ysyx_24080014_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  ysyx_24080014_wb_arb_if.slave bus
);

  logic gnt_exu, gnt_lsu;

  logic             ws_valid_q, ws_valid_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [1:0]       ctl_q, ctl_d;
  logic [11:0]      waddr_q, waddr_d;
  logic             trap_hold_q, trap_hold_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  ysyx_24080014_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .hold    (trap_hold_q),
    .req_exu (bus.exu_valid),
    .req_lsu (bus.lsu_valid),
    .gnt_exu (gnt_exu),
    .gnt_lsu (gnt_lsu)
  );

  always_comb begin
    ws_valid_d   = gnt_exu | gnt_lsu;
    rd_d         = rd_q;
    data_d       = data_q;
    pc_d         = pc_q;
    ctl_d        = ctl_q;
    waddr_d      = waddr_q;
    trap_hold_d  = 1'b0;
    retire_cnt_d = retire_cnt_q + CNT_W'(ws_valid_q);
    unique case (1'b1)
      gnt_lsu: begin
        rd_d    = bus.lsu_rd;
        data_d  = bus.lsu_data;
        pc_d    = bus.lsu_pc;
        ctl_d   = CSRS_NONE;
        waddr_d = 12'd0;
      end
      gnt_exu: begin
        rd_d    = bus.exu_rd;
        data_d  = bus.exu_data;
        pc_d    = bus.exu_pc;
        ctl_d   = bus.exu_csrs_ctl;
        waddr_d = bus.exu_csr_waddr;
        // Freeze grants one cycle so the trap redirect settles.
        trap_hold_d = bus.exu_csrs_ctl != CSRS_NONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_valid_q   <= 1'b0;
      rd_q         <= '0;
      data_q       <= '0;
      pc_q         <= '0;
      ctl_q        <= '0;
      waddr_q      <= '0;
      trap_hold_q  <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      ws_valid_q   <= ws_valid_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
      pc_q         <= pc_d;
      ctl_q        <= ctl_d;
      waddr_q      <= waddr_d;
      trap_hold_q  <= trap_hold_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign bus.exu_ready          = gnt_exu;
  assign bus.lsu_ready          = gnt_lsu;
  assign bus.RegWr              = ws_valid_q &&
    wb_has_effect(rd_q, ctl_q, waddr_q);
  assign bus.rd                 = rd_q;
  assign bus.rd_data            = data_q;
  assign bus.pc                 = pc_q;
  assign bus.csrs_ctl           = ctl_q;
  assign bus.csrs_rs1_write_add = waddr_q;
  assign bus.retire             = ws_valid_q;
  assign bus.retire_cnt         = retire_cnt_q;

endmodule

// File: tb/tb_ysyx_24080014_wb_arb.sv
// Self-checking bench for ysyx_24080014_wb_arb: directed
// scenarios plus randomized traffic against a reference model.
module tb_ysyx_24080014_wb_arb;
  import ysyx_24080014_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ysyx_24080014_wb_arb_if #(.XLEN(32), .CNT_W(32)) bus ();

  ysyx_24080014_wb_arb #(.XLEN(32), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic idle_inputs();
    bus.exu_valid     = 1'b0;
    bus.exu_rd        = '0;
    bus.exu_data      = '0;
    bus.exu_csrs_ctl  = '0;
    bus.exu_csr_waddr = '0;
    bus.exu_pc        = '0;
    bus.lsu_valid     = 1'b0;
    bus.lsu_rd        = '0;
    bus.lsu_data      = '0;
    bus.lsu_pc        = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if (bus.RegWr !== 1'b0 || bus.retire !== 1'b0 ||
        bus.retire_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_ctl RegWr=%b retire=%b cnt=%0d want 0 0 0",
               bus.RegWr, bus.retire, bus.retire_cnt);
    end
    checks++;
    if (bus.rd !== 5'd0 || bus.rd_data !== 32'd0 ||
        bus.pc !== 32'd0 || bus.csrs_ctl !== 2'd0 ||
        bus.csrs_rs1_write_add !== 12'd0) begin
      errors++;
      $display("FAIL reset_payload rd=%0d data=%h pc=%h ctl=%0d wa=%h want all 0",
               bus.rd, bus.rd_data, bus.pc, bus.csrs_ctl,
               bus.csrs_rs1_write_add);
    end
    checks++;
    if (bus.exu_ready !== 1'b0 || bus.lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready exu=%b lsu=%b want 0 0",
               bus.exu_ready, bus.lsu_ready);
    end
    do_reset();
  endtask

  task automatic test_single_exu();
    do_reset();
    @(negedge clk);
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd5;
    bus.exu_data  = 32'h1234;
    bus.exu_pc    = 32'h8000_0000;
    #1;
    checks++;
    if (bus.exu_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b want 1", bus.exu_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.RegWr !== 1'b1 || bus.rd !== 5'd5 ||
        bus.rd_data !== 32'h1234 || bus.retire !== 1'b1) begin
      errors++;
      $display("FAIL single_write RegWr=%b rd=%0d data=%h ret=%b want 1 5 1234 1",
               bus.RegWr, bus.rd, bus.rd_data, bus.retire);
    end
    checks++;
    if (bus.retire_cnt !== 32'd0) begin
      errors++;
      $display("FAIL single_cnt0 got %0d want 0", bus.retire_cnt);
    end
    @(negedge clk);
    bus.exu_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.retire_cnt !== 32'd1 || bus.RegWr !== 1'b0) begin
      errors++;
      $display("FAIL single_cnt1 cnt=%0d RegWr=%b want 1 0",
               bus.retire_cnt, bus.RegWr);
    end
  endtask

  task automatic test_tie();
    logic exp_e;
    do_reset();
    @(negedge clk);
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd1;
    bus.exu_data  = 32'hE0;
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd2;
    bus.lsu_data  = 32'hD0;
    for (int i = 0; i < 4; i++) begin
`ifdef YSYX_24080014_WB_RR_EN
      exp_e = (i % 2) == 0;
`else
      exp_e = 1'b0;
`endif
      #1;
      checks++;
      if (bus.exu_ready !== exp_e ||
          bus.lsu_ready !== !exp_e) begin
        errors++;
        $display("FAIL tie_grant%0d exu=%b lsu=%b want %b %b",
                 i, bus.exu_ready, bus.lsu_ready, exp_e, !exp_e);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.rd !== (exp_e ? 5'd1 : 5'd2) ||
          bus.RegWr !== 1'b1) begin
        errors++;
        $display("FAIL tie_write%0d rd=%0d RegWr=%b want %0d 1",
                 i, bus.rd, bus.RegWr, exp_e ? 1 : 2);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_rd0();
    do_reset();
    @(negedge clk);
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd0;
    bus.lsu_data  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    checks++;
    if (bus.RegWr !== 1'b0 || bus.retire !== 1'b1) begin
      errors++;
      $display("FAIL rd0_write RegWr=%b retire=%b want 0 1",
               bus.RegWr, bus.retire);
    end
    @(negedge clk);
    bus.lsu_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.retire_cnt !== 32'd1) begin
      errors++;
      $display("FAIL rd0_cnt got %0d want 1", bus.retire_cnt);
    end
  endtask

  task automatic test_trap();
    do_reset();
    @(negedge clk);
    bus.exu_valid     = 1'b1;
    bus.exu_rd        = 5'd0;
    bus.exu_data      = 32'hABCD;
    bus.exu_csrs_ctl  = 2'd1;
    bus.exu_csr_waddr = 12'd0;
    bus.exu_pc        = 32'h8000_0010;
    bus.lsu_rd        = 5'd3;
    bus.lsu_data      = 32'h55;
    bus.lsu_pc        = 32'h8000_0020;
`ifdef YSYX_24080014_WB_RR_EN
    bus.lsu_valid = 1'b1;
`endif
    #1;
    checks++;
    if (bus.exu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL trap_grant exu=%b lsu=%b want 1 0",
               bus.exu_ready, bus.lsu_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.csrs_ctl !== 2'd1 || bus.pc !== 32'h8000_0010 ||
        bus.RegWr !== 1'b1) begin
      errors++;
      $display("FAIL trap_commit ctl=%0d pc=%h RegWr=%b want 1 80000010 1",
               bus.csrs_ctl, bus.pc, bus.RegWr);
    end
    @(negedge clk);
    bus.exu_valid    = 1'b0;
    bus.exu_csrs_ctl = 2'd0;
    bus.lsu_valid    = 1'b1;
    #1;
    checks++;
    if (bus.lsu_ready !== 1'b0 || bus.exu_ready !== 1'b0) begin
      errors++;
      $display("FAIL trap_hold exu=%b lsu=%b want 0 0",
               bus.exu_ready, bus.lsu_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.retire !== 1'b0) begin
      errors++;
      $display("FAIL trap_idle retire=%b want 0", bus.retire);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL trap_after lsu_ready=%b want 1", bus.lsu_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.rd !== 5'd3 || bus.csrs_ctl !== 2'd0 ||
        bus.pc !== 32'h8000_0020) begin
      errors++;
      $display("FAIL trap_lsu rd=%0d ctl=%0d pc=%h want 3 0 80000020",
               bus.rd, bus.csrs_ctl, bus.pc);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd7;
    bus.exu_data  = 32'h77;
    @(posedge clk);
    #1;
    checks++;
    if (bus.RegWr !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre RegWr=%b want 1", bus.RegWr);
    end
    rst = 1'b1;
    bus.exu_valid = 1'b0;
    #1;
    checks++;
    if (bus.RegWr !== 1'b0 || bus.retire !== 1'b0 ||
        bus.retire_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rmid_drop RegWr=%b retire=%b cnt=%0d want 0 0 0",
               bus.RegWr, bus.retire, bus.retire_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.retire_cnt !== 32'd0 || bus.RegWr !== 1'b0) begin
      errors++;
      $display("FAIL rmid_after cnt=%0d RegWr=%b want 0 0",
               bus.retire_cnt, bus.RegWr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.retire_cnt_q;
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd9;
    @(posedge clk);
    #1;
    checks++;
    if (bus.retire_cnt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_pre got %h want ffffffff", bus.retire_cnt);
    end
    @(negedge clk);
    bus.exu_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.retire_cnt !== 32'd0) begin
      errors++;
      $display("FAIL wrap got %h want 0", bus.retire_cnt);
    end
  endtask

  function automatic wb_req_t rand_req(input bit exu);
    wb_req_t r;
    logic [11:0] addrs [6];
    int unsigned v;
    addrs = '{12'd0, 12'd0, CSR_MSTATUS, CSR_MTVEC,
              CSR_MEPC, CSR_MCAUSE};
    r.rd        = 5'($urandom_range(0, 31));
    r.data      = $urandom;
    r.pc        = $urandom & 32'hFFFF_FFFC;
    r.csrs_ctl  = 2'd0;
    r.csr_waddr = 12'd0;
    if (exu) begin
      v = $urandom_range(0, 7);
      r.csrs_ctl  = (v < 6) ? 2'd0 : (v == 6) ? 2'd1 : 2'd2;
      r.csr_waddr = addrs[$urandom_range(0, 5)];
    end
    return r;
  endfunction

  task automatic test_random();
    wb_req_t pe, pl, ws;
    bit      pend_e, pend_l, ge, gl, ws_v;
    bit      last_lsu;
    int      hold;
    logic [31:0] cnt;
    logic    exp_wr;
    do_reset();
    pend_e = 0; pend_l = 0; ws_v = 0;
    last_lsu = 1; hold = 0; cnt = 0;
    pe = '0; pl = '0; ws = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!pend_e && $urandom_range(0, 2) != 0) begin
        pe = rand_req(1'b1);
        pend_e = 1;
      end
      if (!pend_l && $urandom_range(0, 2) != 0) begin
        pl = rand_req(1'b0);
        pend_l = 1;
      end
      bus.exu_valid     = pend_e;
      bus.exu_rd        = pe.rd;
      bus.exu_data      = pe.data;
      bus.exu_csrs_ctl  = pe.csrs_ctl;
      bus.exu_csr_waddr = pe.csr_waddr;
      bus.exu_pc        = pe.pc;
      bus.lsu_valid     = pend_l;
      bus.lsu_rd        = pl.rd;
      bus.lsu_data      = pl.data;
      bus.lsu_pc        = pl.pc;
      #1;
      ge = 0; gl = 0;
      if (hold == 0) begin
        if (pend_e && pend_l) begin
`ifdef YSYX_24080014_WB_RR_EN
          ge = last_lsu;
          gl = !last_lsu;
`else
          gl = 1;
`endif
        end else begin
          ge = pend_e;
          gl = pend_l;
        end
      end
      checks++;
      if (bus.exu_ready !== ge || bus.lsu_ready !== gl) begin
        errors++;
        $display("FAIL rnd_ready c=%0d exu=%b lsu=%b want %b %b",
                 c, bus.exu_ready, bus.lsu_ready, ge, gl);
      end
      @(posedge clk);
      if (ws_v) cnt = cnt + 1;
      if (hold > 0) hold--;
      ws_v = ge || gl;
      if (gl) begin
        ws = pl;
        ws.csrs_ctl  = 2'd0;
        ws.csr_waddr = 12'd0;
        last_lsu = 1;
        pend_l = 0;
      end else if (ge) begin
        ws = pe;
        last_lsu = 0;
        pend_e = 0;
        if (pe.csrs_ctl != 2'd0) hold = 1;
      end
      exp_wr = ws_v && (ws.rd != 0 || ws.csrs_ctl != 0 ||
                        ws.csr_waddr != 0);
      #1;
      checks++;
      if (bus.retire !== ws_v || bus.RegWr !== exp_wr ||
          bus.retire_cnt !== cnt) begin
        errors++;
        $display("FAIL rnd_ctl c=%0d ret=%b wr=%b cnt=%0d want %b %b %0d",
                 c, bus.retire, bus.RegWr, bus.retire_cnt,
                 ws_v, exp_wr, cnt);
      end
      if (ws_v) begin
        checks++;
        if (bus.rd !== ws.rd || bus.rd_data !== ws.data ||
            bus.pc !== ws.pc || bus.csrs_ctl !== ws.csrs_ctl ||
            bus.csrs_rs1_write_add !== ws.csr_waddr) begin
          errors++;
          $display("FAIL rnd_pay c=%0d rd=%0d d=%h pc=%h ctl=%0d wa=%h want %0d %h %h %0d %h",
                   c, bus.rd, bus.rd_data, bus.pc, bus.csrs_ctl,
                   bus.csrs_rs1_write_add, ws.rd, ws.data,
                   ws.pc, ws.csrs_ctl, ws.csr_waddr);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_exu();
    test_tie();
    test_rd0();
    test_trap();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
